// File: rtl/tilemap_scroll_gen_if.sv
// Purpose : VRAM fetch bus between the scroll generator (master) and memory (slave).
// Latency : master holds req/addr stable until ack; one transfer per ack cycle.
// Backpr. : slave stalls a fetch simply by delaying ack; data is valid on the ack cycle.
// Signals : req (fetch request), addr (byte address), ack (fetch complete), data (fetched byte).
interface tilemap_scroll_gen_if #(
  parameter int AW = 13
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [7:0]    data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/tilemap_scroll_gen.sv
// Purpose : per-scanline fetch of per-layer X/Y scroll values from VRAM, then per-pixel
//           tilemap coordinate generation (tile column/row, row-in-tile, fine X).
// Latency : pixel outputs registered, one cycle after pxh/row/flip_screen; scroll values
//           fetched during line N are committed on the line_start of line N+1.
// Backpr. : VRAM fetches stall on ack; a line_start arriving mid-sequence flags fetch_err,
//           keeps the active scroll set and restarts the fetch sequence from layer 0.
// Ports   : clk, reset (sync, active-high); line_start/next_line line timing; pxh/row/flip_screen
//           raster position; mode/y_en per-layer config; vram fetch bus (master);
//           map_col/map_row/row_s/fine per-layer packed outputs (layer L in slice L); fetch_err.
// XW is expected to lie in 9..16: the X scroll is assembled from a low byte plus high byte.
module tilemap_scroll_gen #(
  parameter int             NUM_LAYERS   = 2,
  parameter int             XW           = 9,
  parameter int             YW           = 8,
  parameter int             AW           = 13,
  parameter logic [AW-1:0]  SCROLL_BASE  = 13'h1A00,
  parameter logic [AW-1:0]  LAYER_STRIDE = 13'h0400,
  parameter logic [XW-1:0]  FLIP_XOFS    = 9'h1F9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          line_start,
  input  logic [7:0]                    next_line,
  input  logic [XW-1:0]                 pxh,
  input  logic [YW-1:0]                 row,
  input  logic                          flip_screen,
  input  logic [2*NUM_LAYERS-1:0]       mode,
  input  logic [NUM_LAYERS-1:0]         y_en,
  tilemap_scroll_gen_if.master          vram,
  output logic [NUM_LAYERS*(XW-3)-1:0]  map_col,
  output logic [NUM_LAYERS*(YW-3)-1:0]  map_row,
  output logic [NUM_LAYERS*3-1:0]       row_s,
  output logic [NUM_LAYERS*3-1:0]       fine,
  output logic                          fetch_err
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_XL,
    S_FETCH_XH,
    S_FETCH_Y,
    S_NEXT
  } state_t;

  state_t                state, state_n;
  logic [LW-1:0]         layer, layer_n;
  logic                  ready, ready_n;
  logic                  req_q, req_n;
  logic [AW-1:0]         addr_q, addr_n;

  // Line number and modes frozen for the duration of one fetch sequence.
  logic [7:0]            nl_q;
  logic [2*NUM_LAYERS-1:0] mode_q;

  logic                  start, commit, overrun;
  logic                  cap_xl, cap_xh, cap_y, clr_y;

  logic [1:0]            lmode;
  logic [7:0]            idx;
  logic [AW-1:0]         layer_base;
  logic [AW-1:0]         fetch_addr;

  logic [XW-1:0]         sx_sh  [NUM_LAYERS];
  logic [XW-1:0]         sx_act [NUM_LAYERS];
  logic [YW-1:0]         sy_sh  [NUM_LAYERS];
  logic [YW-1:0]         sy_act [NUM_LAYERS];

  logic [NUM_LAYERS*(XW-3)-1:0] map_col_n;
  logic [NUM_LAYERS*(YW-3)-1:0] map_row_n;
  logic [NUM_LAYERS*3-1:0]      row_s_n;
  logic [NUM_LAYERS*3-1:0]      fine_n;

  assign vram.req  = req_q;
  assign vram.addr = addr_q;

  // ---------------------------------------------------------------------------
  // Fetch address for the current layer/state
  // ---------------------------------------------------------------------------
  always_comb begin
    lmode = mode_q[{layer, 1'b0} +: 2];
    idx   = 8'h00;
    case (lmode)
      2'b01:   idx = {3'b000, nl_q[7:3]};
      2'b10:   idx = nl_q;
      default: idx = 8'h00;  // 00 and 11 both select the global entry
    endcase
    layer_base = SCROLL_BASE + AW'(layer) * LAYER_STRIDE;
    case (state)
      S_FETCH_XL: fetch_addr = layer_base + AW'({idx, 1'b0});
      S_FETCH_XH: fetch_addr = layer_base + AW'({idx, 1'b1});
      S_FETCH_Y:  fetch_addr = layer_base + AW'(10'h200);
      default:    fetch_addr = layer_base;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch sequencer: next state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    layer_n = layer;
    ready_n = ready;
    req_n   = req_q;
    addr_n  = addr_q;
    start   = 1'b0;
    commit  = 1'b0;
    overrun = 1'b0;
    cap_xl  = 1'b0;
    cap_xh  = 1'b0;
    cap_y   = 1'b0;
    clr_y   = 1'b0;

    if (line_start) begin
      // Every line_start (re)starts the sequence at layer 0 and drops any
      // outstanding request; only a start from IDLE may commit.
      start   = 1'b1;
      state_n = S_FETCH_XL;
      layer_n = '0;
      req_n   = 1'b0;
      if (state == S_IDLE) begin
        commit  = ready;
        ready_n = 1'b0;
      end else begin
        overrun = 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_FETCH_XL, S_FETCH_XH, S_FETCH_Y: begin
          if (!req_q) begin
            // Issue cycle; also provides the idle gap after the previous ack.
            req_n  = 1'b1;
            addr_n = fetch_addr;
          end else if (vram.ack) begin
            req_n = 1'b0;
            if (state == S_FETCH_XL) begin
              cap_xl  = 1'b1;
              state_n = S_FETCH_XH;
            end else if (state == S_FETCH_XH) begin
              cap_xh = 1'b1;
              if (y_en[layer]) begin
                state_n = S_FETCH_Y;
              end else begin
                clr_y   = 1'b1;
                state_n = S_NEXT;
              end
            end else begin
              cap_y   = 1'b1;
              state_n = S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (layer == LAST_LAYER) begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end else begin
            layer_n = layer + LW'(1);
            state_n = S_FETCH_XL;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      layer     <= '0;
      ready     <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      fetch_err <= 1'b0;
      nl_q      <= '0;
      mode_q    <= '0;
    end else begin
      state     <= state_n;
      layer     <= layer_n;
      ready     <= ready_n;
      req_q     <= req_n;
      addr_q    <= addr_n;
      fetch_err <= overrun;
      if (start) begin
        nl_q   <= next_line;
        mode_q <= mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow (being fetched) and active (in use) scroll registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (reset) begin
        sx_sh[i]  <= '0;
        sy_sh[i]  <= '0;
        sx_act[i] <= '0;
        sy_act[i] <= '0;
      end else begin
        if (layer == LW'(i)) begin
          if (cap_xl) sx_sh[i][7:0] <= vram.data;
          // High byte above the low byte; only the bits that fit XW survive.
          if (cap_xh) sx_sh[i] <= XW'({vram.data, sx_sh[i][7:0]});
          if (cap_y)  sy_sh[i] <= YW'(vram.data);
          if (clr_y)  sy_sh[i] <= '0;
        end
        if (commit) begin
          sx_act[i] <= sx_sh[i];
          sy_act[i] <= sy_sh[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-layer pixel coordinate generation
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pix
    logic [XW-1:0] add_x;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;

    assign add_x = sx_act[g] + (flip_screen ? FLIP_XOFS : XW'(0));
    assign ex    = pxh + add_x;
    assign ey    = row + sy_act[g];

    assign map_col_n[g*(XW-3) +: (XW-3)] = ex[XW-1:3];
    // Flipped screens walk the tile right-to-left, so fine X is mirrored.
    assign fine_n[g*3 +: 3]              = ex[2:0] ^ {3{flip_screen}};
    assign map_row_n[g*(YW-3) +: (YW-3)] = ey[YW-1:3];
    assign row_s_n[g*3 +: 3]             = ey[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_col <= '0;
      map_row <= '0;
      row_s   <= '0;
      fine    <= '0;
    end else begin
      map_col <= map_col_n;
      map_row <= map_row_n;
      row_s   <= row_s_n;
      fine    <= fine_n;
    end
  end

endmodule

// File: tb/tb_tilemap_scroll_gen.sv
module tb_tilemap_scroll_gen;
  localparam int NL = 2;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int AW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  line_start;
  logic [7:0]            next_line;
  logic [XW-1:0]         pxh;
  logic [YW-1:0]         row;
  logic                  flip_screen;
  logic [2*NL-1:0]       mode;
  logic [NL-1:0]         y_en;
  logic [NL*(XW-3)-1:0]  map_col;
  logic [NL*(YW-3)-1:0]  map_row;
  logic [NL*3-1:0]       row_s;
  logic [NL*3-1:0]       fine;
  logic                  fetch_err;

  tilemap_scroll_gen_if #(.AW(AW)) vram ();

  tilemap_scroll_gen dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .next_line   (next_line),
    .pxh         (pxh),
    .row         (row),
    .flip_screen (flip_screen),
    .mode        (mode),
    .y_en        (y_en),
    .vram        (vram),
    .map_col     (map_col),
    .map_row     (map_row),
    .row_s       (row_s),
    .fine        (fine),
    .fetch_err   (fetch_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]    xl_v [NL];
  logic [7:0]    xh_v [NL];
  logic [7:0]    y_v  [NL];
  logic          ack_enable = 1'b1;
  logic          block_en   = 1'b0;
  logic [AW-1:0] block_addr = '0;
  logic [AW-1:0] addr_log [$];

  // Memory model: layer tables at 0x1A00 + L*0x400; X pairs by parity, Y at +0x200.
  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    int ly;
    int lo;
    off = a - 13'h1A00;
    ly  = (off >= 13'h0400) ? 1 : 0;
    lo  = int'(off) - ly * 1024;
    if (lo == 'h200) return y_v[ly];
    else if ((lo % 2) == 1) return xh_v[ly];
    else return xl_v[ly];
  endfunction

  // One-cycle ack for each request seen, unless disabled or the address is blocked.
  initial begin
    vram.ack  = 1'b0;
    vram.data = 8'h00;
    forever begin
      @(negedge clk);
      if (vram.req && !vram.ack && ack_enable && !(block_en && vram.addr == block_addr)) begin
        vram.ack  = 1'b1;
        vram.data = mem_rd(vram.addr);
        addr_log.push_back(vram.addr);
      end else begin
        vram.ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_line(input logic [7:0] nl, input logic [3:0] md);
    next_line  = nl;
    mode       = md;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic run_line(input logic [7:0] nl, input logic [3:0] md);
    pulse_line(nl, md);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; line_start = 1'b0; next_line = 8'h00;
    pxh = 9'h015; row = 8'h2B; flip_screen = 1'b1; mode = 4'b0000; y_en = 2'b11;
    repeat (3) @(negedge clk);
    checks++; if (vram.req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", vram.req); end
    checks++; if (vram.addr !== 13'h0) begin errors++; $display("FAIL reset_addr got %0h want 0", vram.addr); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h want 0", fetch_err); end
    checks++; if (map_col !== '0) begin errors++; $display("FAIL reset_map_col got %0h want 0", map_col); end
    checks++; if (map_row !== '0) begin errors++; $display("FAIL reset_map_row got %0h want 0", map_row); end
    checks++; if (row_s !== '0) begin errors++; $display("FAIL reset_row_s got %0h want 0", row_s); end
    checks++; if (fine !== '0) begin errors++; $display("FAIL reset_fine got %0h want 0", fine); end
    reset = 1'b0; flip_screen = 1'b0; pxh = 9'h000; row = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_global();
    logic [AW-1:0] exp_a [6];
    exp_a = '{13'h1A00, 13'h1A01, 13'h1C00, 13'h1E00, 13'h1E01, 13'h2000};
    for (int l = 0; l < NL; l++) begin xl_v[l] = 8'h05; xh_v[l] = 8'h01; y_v[l] = 8'h10; end
    addr_log.delete();
    run_line(8'h00, 4'b0000);
    checks++; if (addr_log.size() !== 6) begin errors++; $display("FAIL global_req_count got %0d want 6", addr_log.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= addr_log.size()) begin errors++; $display("FAIL global_addr%0d missing want %0h", i, exp_a[i]); end
      else if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL global_addr%0d got %0h want %0h", i, addr_log[i], exp_a[i]); end
    end
    run_line(8'h00, 4'b0000);  // commits the fetched values
    for (int l = 0; l < NL; l++) begin
      checks++; if (map_col[l*6 +: 6] !== 6'h20) begin errors++; $display("FAIL global_map_col L%0d got %0h want 20", l, map_col[l*6 +: 6]); end
      checks++; if (fine[l*3 +: 3] !== 3'd5) begin errors++; $display("FAIL global_fine L%0d got %0h want 5", l, fine[l*3 +: 3]); end
      checks++; if (map_row[l*5 +: 5] !== 5'd2) begin errors++; $display("FAIL global_map_row L%0d got %0h want 2", l, map_row[l*5 +: 5]); end
      checks++; if (row_s[l*3 +: 3] !== 3'd0) begin errors++; $display("FAIL global_row_s L%0d got %0h want 0", l, row_s[l*3 +: 3]); end
    end
  endtask

  task automatic test_per_line();
    logic [AW-1:0] exp_a [6];
    // layer 0 per-8-line (idx 6), layer 1 per-line (idx 0x37)
    exp_a = '{13'h1A0C, 13'h1A0D, 13'h1C00, 13'h1E6E, 13'h1E6F, 13'h2000};
    addr_log.delete();
    run_line(8'h37, 4'b1001);
    checks++; if (addr_log.size() !== 6) begin errors++; $display("FAIL perline_req_count got %0d want 6", addr_log.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= addr_log.size()) begin errors++; $display("FAIL perline_addr%0d missing want %0h", i, exp_a[i]); end
      else if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL perline_addr%0d got %0h want %0h", i, addr_log[i], exp_a[i]); end
    end
  endtask

  task automatic test_no_y();
    logic [AW-1:0] exp_a [5];
    exp_a = '{13'h1A00, 13'h1A01, 13'h1C00, 13'h1E00, 13'h1E01};
    y_en = 2'b01;
    addr_log.delete();
    run_line(8'h00, 4'b0000);
    checks++; if (addr_log.size() !== 5) begin errors++; $display("FAIL noy_req_count got %0d want 5", addr_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= addr_log.size()) begin errors++; $display("FAIL noy_addr%0d missing want %0h", i, exp_a[i]); end
      else if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL noy_addr%0d got %0h want %0h", i, addr_log[i], exp_a[i]); end
    end
    row = 8'h2B;
    run_line(8'h00, 4'b0000);
    // layer 0: 0x2B+0x10=0x3B ; layer 1: Y forced to 0 -> 0x2B
    checks++; if (map_row[0 +: 5] !== 5'd7) begin errors++; $display("FAIL noy_map_row L0 got %0h want 7", map_row[0 +: 5]); end
    checks++; if (row_s[0 +: 3] !== 3'd3) begin errors++; $display("FAIL noy_row_s L0 got %0h want 3", row_s[0 +: 3]); end
    checks++; if (map_row[5 +: 5] !== 5'd5) begin errors++; $display("FAIL noy_map_row L1 got %0h want 5", map_row[5 +: 5]); end
    checks++; if (row_s[3 +: 3] !== 3'd3) begin errors++; $display("FAIL noy_row_s L1 got %0h want 3", row_s[3 +: 3]); end
    y_en = 2'b11;
    row  = 8'h00;
  endtask

  task automatic test_wrap();
    xl_v[0] = 8'hFF; xh_v[0] = 8'h01;   // layer 0 SX = 0x1FF, layer 1 stays 0x105
    pxh = 9'h003;
    run_line(8'h00, 4'b0000);
    run_line(8'h00, 4'b0000);
    checks++; if (map_col[0 +: 6] !== 6'h00) begin errors++; $display("FAIL wrap_map_col L0 got %0h want 0", map_col[0 +: 6]); end
    checks++; if (fine[0 +: 3] !== 3'd2) begin errors++; $display("FAIL wrap_fine L0 got %0h want 2", fine[0 +: 3]); end
    checks++; if (map_col[6 +: 6] !== 6'h21) begin errors++; $display("FAIL wrap_map_col L1 got %0h want 21", map_col[6 +: 6]); end
    checks++; if (fine[3 +: 3] !== 3'd0) begin errors++; $display("FAIL wrap_fine L1 got %0h want 0", fine[3 +: 3]); end
    flip_screen = 1'b1;
    repeat (2) @(negedge clk);
    // L0: 0x1FF+0x1F9+3 = 0x1FB ; L1: 0x105+0x1F9+3 = 0x101 (mod 512), fine inverted
    checks++; if (map_col[0 +: 6] !== 6'h3F) begin errors++; $display("FAIL flip_map_col L0 got %0h want 3f", map_col[0 +: 6]); end
    checks++; if (fine[0 +: 3] !== 3'd4) begin errors++; $display("FAIL flip_fine L0 got %0h want 4", fine[0 +: 3]); end
    checks++; if (map_col[6 +: 6] !== 6'h20) begin errors++; $display("FAIL flip_map_col L1 got %0h want 20", map_col[6 +: 6]); end
    checks++; if (fine[3 +: 3] !== 3'd6) begin errors++; $display("FAIL flip_fine L1 got %0h want 6", fine[3 +: 3]); end
    flip_screen = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun();
    int n;
    xl_v[0]    = 8'h22;
    block_addr = 13'h1C00;
    block_en   = 1'b1;
    pulse_line(8'h00, 4'b0000);
    n = 0;
    while (!(vram.req === 1'b1 && vram.addr === 13'h1C00) && n < 30) begin @(negedge clk); n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL overrun_wait_y got timeout want req at 1c00"); end
    pulse_line(8'h00, 4'b0000);
    addr_log.delete();
    block_en = 1'b0;
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL overrun_err got %0h want 1", fetch_err); end
    checks++; if (vram.req !== 1'b0) begin errors++; $display("FAIL overrun_req_drop got %0h want 0", vram.req); end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL overrun_err_pulse got %0h want 0", fetch_err); end
    checks++; if (map_col[0 +: 6] !== 6'h00) begin errors++; $display("FAIL overrun_keep_col got %0h want 0", map_col[0 +: 6]); end
    checks++; if (fine[0 +: 3] !== 3'd2) begin errors++; $display("FAIL overrun_keep_fine got %0h want 2", fine[0 +: 3]); end
    n = 0;
    while (addr_log.size() == 0 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (addr_log.size() == 0) begin errors++; $display("FAIL overrun_restart got timeout want 1a00"); end
    else if (addr_log[0] !== 13'h1A00) begin errors++; $display("FAIL overrun_restart got %0h want 1a00", addr_log[0]); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    ack_enable = 1'b0;
    pulse_line(8'h00, 4'b0000);  // commits SX0 = 0x122 from the restarted sequence
    @(negedge clk);
    checks++; if (map_col[0 +: 6] !== 6'h24) begin errors++; $display("FAIL commit_col L0 got %0h want 24", map_col[0 +: 6]); end
    checks++; if (fine[0 +: 3] !== 3'd5) begin errors++; $display("FAIL commit_fine L0 got %0h want 5", fine[0 +: 3]); end
    n = 0;
    while (vram.req !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL rstmid_wait_req got timeout want req"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_enable = 1'b1;
    checks++; if (vram.req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0h want 0", vram.req); end
    checks++; if (vram.addr !== 13'h0) begin errors++; $display("FAIL rstmid_addr got %0h want 0", vram.addr); end
    checks++; if (map_col !== '0) begin errors++; $display("FAIL rstmid_map_col got %0h want 0", map_col); end
    checks++; if (fine !== '0) begin errors++; $display("FAIL rstmid_fine got %0h want 0", fine); end
    @(negedge clk);
    checks++; if (vram.req !== 1'b0) begin errors++; $display("FAIL rstmid_idle_req got %0h want 0", vram.req); end
    addr_log.delete();
    pulse_line(8'h00, 4'b0000);  // ready is clear: no commit, active stays 0
    @(negedge clk);
    checks++; if (fine !== 6'b011011) begin errors++; $display("FAIL rstmid_nocommit_fine got %0h want 1b", fine); end
    checks++; if (map_col !== '0) begin errors++; $display("FAIL rstmid_nocommit_col got %0h want 0", map_col); end
    n = 0;
    while (addr_log.size() == 0 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (addr_log.size() == 0) begin errors++; $display("FAIL rstmid_first_req got timeout want 1a00"); end
    else if (addr_log[0] !== 13'h1A00) begin errors++; $display("FAIL rstmid_first_req got %0h want 1a00", addr_log[0]); end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_global();
    test_per_line();
    test_no_y();
    test_wrap();
    test_overrun();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
